// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one external combinational ALU among NREQ requesters.
// Round-robin grant in IDLE, one operation in flight at a time, with a register
// stage on each side of the ALU (operands out, result/zero back in).
// Optional feature macro: ALU_ARB_OPCHECK_EN. When defined, illegal opcodes are
// rejected at accept time with rsp_err=1 and never reach the ALU.
module alu_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*4-1:0]     req_op,
  output logic [WIDTH-1:0]      alu_in0,
  output logic [WIDTH-1:0]      alu_in1,
  output logic [3:0]            alu_ctrl,
  input  logic [WIDTH-1:0]      alu_res,
  input  logic                  alu_zero,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_res,
  output logic                  rsp_zero,
  output logic                  rsp_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     owner;
  logic [PW-1:0]     grant_idx;
  logic [PW-1:0]     cand;
  logic [PW-1:0]     next_ptr;
  logic              grant_any;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [3:0]        sel_op;

  // Requester index k places after the round-robin pointer, wrapping at NREQ.
  function automatic logic [PW-1:0] scan_idx(input logic [PW-1:0] ptr, input int k);
    int sum;
    sum = int'(ptr) + k;
    if (sum >= NREQ) sum = sum - NREQ;
    return PW'(sum);
  endfunction

  function automatic logic [NREQ-1:0] to_onehot(input logic [PW-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin search: first valid requester starting at rr_ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = scan_idx(rr_ptr, k);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign sel_a    = req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_b    = req_b[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_op   = req_op[int'(grant_idx)*4 +: 4];
  assign next_ptr = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);

  // Only the IDLE state offers a grant; at most one bit is ever set.
  assign req_ready = (state == IDLE && grant_any) ? to_onehot(grant_idx) : '0;

`ifdef ALU_ARB_OPCHECK_EN
  logic err_q;
  logic op_legal;

  assign op_legal = (sel_op == 4'b0000) || (sel_op == 4'b0001) ||
                    (sel_op == 4'b0010) || (sel_op == 4'b0110);
  assign rsp_err  = err_q;

  // Arbitration FSM with opcode screening: illegal ops bypass the ALU entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      alu_in0   <= '0;
      alu_in1   <= '0;
      alu_ctrl  <= 4'b0010;
      rsp_valid <= '0;
      rsp_res   <= '0;
      rsp_zero  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner   <= grant_idx;
            rr_ptr  <= next_ptr;
            alu_in0 <= sel_a;
            alu_in1 <= sel_b;
            if (op_legal) begin
              alu_ctrl <= sel_op;
              err_q    <= 1'b0;
              state    <= EXEC;
            end else begin
              err_q     <= 1'b1;
              rsp_res   <= '0;
              rsp_zero  <= 1'b0;
              rsp_valid <= to_onehot(grant_idx);
              state     <= RESP;
            end
          end
        end
        EXEC: begin
          rsp_res   <= alu_res;
          rsp_zero  <= alu_zero;
          rsp_valid <= to_onehot(owner);
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign rsp_err = 1'b0;

  // Arbitration FSM: every accepted op is forwarded to the ALU through EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      alu_in0   <= '0;
      alu_in1   <= '0;
      alu_ctrl  <= 4'b0010;
      rsp_valid <= '0;
      rsp_res   <= '0;
      rsp_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner    <= grant_idx;
            rr_ptr   <= next_ptr;
            alu_in0  <= sel_a;
            alu_in1  <= sel_b;
            alu_ctrl <= sel_op;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_res   <= alu_res;
          rsp_zero  <= alu_zero;
          rsp_valid <= to_onehot(owner);
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed bench for alu_rr_arbiter with an ALU stand-in,
// a transaction-level reference model and hand-computed literal expectations.
// Honours ALU_ARB_OPCHECK_EN the same way the design does.
module tb_alu_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 64;
`ifdef ALU_ARB_OPCHECK_EN
  localparam bit OPCHECK = 1'b1;
`else
  localparam bit OPCHECK = 1'b0;
`endif

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*4-1:0]     req_op;
  logic [WIDTH-1:0]      alu_in0;
  logic [WIDTH-1:0]      alu_in1;
  logic [3:0]            alu_ctrl;
  logic [WIDTH-1:0]      alu_res;
  logic                  alu_zero;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_res;
  logic                  rsp_zero;
  logic                  rsp_err;

  int vectors    = 0;
  int miscompares = 0;
  bit cmpOn      = 1'b0;

  alu_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_in0   (alu_in0),
    .alu_in1   (alu_in1),
    .alu_ctrl  (alu_ctrl),
    .alu_res   (alu_res),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared ALU; unsupported codes produce an arbitrary value.
  always_comb begin
    case (alu_ctrl)
      4'b0010: alu_res = alu_in0 + alu_in1;
      4'b0110: alu_res = alu_in0 - alu_in1;
      4'b0000: alu_res = alu_in0 & alu_in1;
      4'b0001: alu_res = alu_in0 | alu_in1;
      default: alu_res = alu_in0 ^ alu_in1;
    endcase
    alu_zero = (alu_res == '0);
  end

  function automatic bit isLegal(input logic [3:0] op);
    return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010) || (op == 4'b0110);
  endfunction

  function automatic logic [63:0] aluRef(input logic [63:0] a, input logic [63:0] b,
                                         input logic [3:0] op);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic int rrGrant(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, tracked as busy/wait-cycles.
  bit          m_busy;
  int          m_wait;
  int          m_owner;
  int          m_ptr;
  logic [3:0]  m_ctrl;
  logic [63:0] m_in0, m_in1, m_res;
  bit          m_in_known, m_res_known, m_zero, m_err;

  int          mGrant;
  logic [63:0] mA, mB;
  logic [3:0]  mOp;
  logic [3:0]  expReady, expValid;

  always_comb begin
    mGrant   = rrGrant(m_ptr, req_valid);
    mA       = '0;
    mB       = '0;
    mOp      = '0;
    if (mGrant >= 0) begin
      mA  = req_a[mGrant*WIDTH +: WIDTH];
      mB  = req_b[mGrant*WIDTH +: WIDTH];
      mOp = req_op[mGrant*4 +: 4];
    end
    expReady = (!m_busy && mGrant >= 0) ? 4'(1 << mGrant) : 4'b0000;
    expValid = (m_busy && m_wait == 0) ? 4'(1 << m_owner) : 4'b0000;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy      <= 1'b0;
      m_wait      <= 0;
      m_owner     <= 0;
      m_ptr       <= 0;
      m_ctrl      <= 4'b0010;
      m_in0       <= '0;
      m_in1       <= '0;
      m_in_known  <= 1'b1;
      m_res       <= '0;
      m_res_known <= 1'b1;
      m_zero      <= 1'b0;
      m_err       <= 1'b0;
    end else if (!m_busy) begin
      if (mGrant >= 0) begin
        m_busy  <= 1'b1;
        m_owner <= mGrant;
        m_ptr   <= (mGrant + 1) % NREQ;
        if (OPCHECK && !isLegal(mOp)) begin
          m_in_known  <= 1'b0;
          m_res       <= '0;
          m_zero      <= 1'b0;
          m_err       <= 1'b1;
          m_res_known <= 1'b1;
          m_wait      <= 0;
        end else begin
          m_ctrl      <= mOp;
          m_in0       <= mA;
          m_in1       <= mB;
          m_in_known  <= 1'b1;
          m_res       <= aluRef(mA, mB, mOp);
          m_zero      <= (aluRef(mA, mB, mOp) == 64'd0);
          m_err       <= 1'b0;
          m_res_known <= isLegal(mOp);
          m_wait      <= 1;
        end
      end
    end else if (m_wait != 0) begin
      m_wait <= m_wait - 1;
    end else if (rsp_ready[m_owner]) begin
      m_busy <= 1'b0;
    end
  end

  // Compare process: DUT against the model on every out-of-reset cycle.
  always @(negedge clk) begin
    if (rst_n && cmpOn) begin
      checkOutput("mdl_req_ready", req_ready, expReady);
      checkOutput("mdl_rsp_valid", rsp_valid, expValid);
      checkOutput("mdl_alu_ctrl", alu_ctrl, m_ctrl);
      if (m_in_known) begin
        checkOutput("mdl_alu_in0", alu_in0, m_in0);
        checkOutput("mdl_alu_in1", alu_in1, m_in1);
      end
      if (expValid != 0) begin
        checkOutput("mdl_rsp_err", rsp_err, OPCHECK ? m_err : 1'b0);
        if (m_res_known) begin
          checkOutput("mdl_rsp_res", rsp_res, m_res);
          checkOutput("mdl_rsp_zero", rsp_zero, m_zero);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] ready);
    req_valid = valid;
    rsp_ready = ready;
  endtask

  task automatic setReq(input int idx, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] op);
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
    req_op[idx*4 +: 4]        = op;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 64'd0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 64'd0);
    checkOutput({tag, "_rsp_res"}, rsp_res, 64'd0);
    checkOutput({tag, "_rsp_zero"}, rsp_zero, 64'd0);
    checkOutput({tag, "_rsp_err"}, rsp_err, 64'd0);
    checkOutput({tag, "_alu_in0"}, alu_in0, 64'd0);
    checkOutput({tag, "_alu_in1"}, alu_in1, 64'd0);
    checkOutput({tag, "_alu_ctrl"}, alu_ctrl, 64'h2);
  endtask

  // One isolated request from requester idx, with literal expectations.
  task automatic singleOp(input int idx, input logic [63:0] expRes, input bit expZero,
                          input bit expErr, input int lat, input bit chkRes);
    logic [NREQ-1:0] bitv;
    bitv = 4'b0001 << idx;
    applyStimulus(bitv, 4'b0000);
    @(negedge clk);
    checkOutput("op_grant", req_ready, bitv);
    @(posedge clk); #1;
    applyStimulus(4'b0000, 4'b0000);
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      checkOutput("op_early_rsp", rsp_valid, 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("op_rsp_valid", rsp_valid, bitv);
    checkOutput("op_rsp_err", rsp_err, expErr);
    if (chkRes) begin
      checkOutput("op_rsp_res", rsp_res, expRes);
      checkOutput("op_rsp_zero", rsp_zero, expZero);
    end
    rsp_ready = bitv;
    @(posedge clk); #1;
    rsp_ready = 4'b0000;
    @(negedge clk);
    checkOutput("op_rsp_done", rsp_valid, 64'd0);
    @(posedge clk); #1;
  endtask

  int gq[$];
  int gc[$];
  int expOrder[5] = '{0, 1, 2, 3, 0};

  initial begin
    int cyc;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("rst");
    rst_n = 1'b1;
    cmpOn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single add and subtract cases");
    setReq(0, 64'd5, 64'd3, 4'b0010);
    singleOp(0, 64'd8, 1'b0, 1'b0, 2, 1'b1);
    setReq(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0110);
    singleOp(1, 64'd0, 1'b1, 1'b0, 2, 1'b1);
    setReq(3, 64'd0, 64'd1, 4'b0110);
    singleOp(3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 2, 1'b1);

    $display("[TB] round-robin fairness");
    setReq(0, 64'd10, 64'd20, 4'b0010);
    setReq(1, 64'd50, 64'd8, 4'b0110);
    setReq(2, 64'hF0, 64'h3C, 4'b0000);
    setReq(3, 64'hF0, 64'h0F, 4'b0001);
    applyStimulus(4'b1111, 4'b1111);
    cyc = 0;
    while (gq.size() < 5 && cyc < 40) begin
      @(negedge clk);
      if (req_ready != 0) begin
        for (int k = 0; k < NREQ; k++)
          if (req_ready[k]) gq.push_back(k);
        gc.push_back(cyc);
      end
      cyc++;
    end
    if (gq.size() < 5) checkOutput("fair_timeout", gq.size(), 64'd5);
    for (int i = 0; i < gq.size() && i < 5; i++)
      checkOutput("fair_order", gq[i], expOrder[i]);
    for (int i = 1; i < gc.size(); i++)
      checkOutput("fair_gap", gc[i] - gc[i-1], 64'd3);
    @(posedge clk); #1;
    applyStimulus(4'b0000, 4'b1111);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(4'b0000, 4'b0000);

    $display("[TB] response backpressure on owner 2");
    setReq(2, 64'd1, 64'd2, 4'b0010);
    applyStimulus(4'b0100, 4'b0000);
    @(negedge clk);
    checkOutput("bp_grant", req_ready, 64'h4);
    @(posedge clk); #1;
    applyStimulus(4'b1011, 4'b1011);
    @(posedge clk); #1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("bp_valid", rsp_valid, 64'h4);
      checkOutput("bp_res", rsp_res, 64'd3);
      checkOutput("bp_ready", req_ready, 64'd0);
      @(posedge clk); #1;
    end
    applyStimulus(4'b0000, 4'b0100);
    @(posedge clk); #1;
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("bp_release", rsp_valid, 64'd0);
    @(posedge clk); #1;

    $display("[TB] reset during EXEC");
    setReq(1, 64'd7, 64'd9, 4'b0010);
    applyStimulus(4'b0010, 4'b0000);
    @(posedge clk); #1;
    applyStimulus(4'b0000, 4'b0000);
    #1;
    rst_n = 1'b0;
    #1;
    checkReset("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_no_stale", rsp_valid, 64'd0);
    end
    @(posedge clk); #1;
    setReq(0, 64'd4, 64'd6, 4'b0001);
    applyStimulus(4'b1111, 4'b1111);
    @(negedge clk);
    checkOutput("rst_first_grant", req_ready, 64'h1);
    @(posedge clk); #1;
    applyStimulus(4'b0000, 4'b1111);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(4'b0000, 4'b0000);

    $display("[TB] unsupported opcode 0111");
    setReq(0, 64'd9, 64'd9, 4'b0111);
`ifdef ALU_ARB_OPCHECK_EN
    singleOp(0, 64'd0, 1'b0, 1'b1, 1, 1'b1);
    checkOutput("opchk_ctrl_kept", alu_ctrl, 64'h1);
`else
    singleOp(0, 64'd0, 1'b0, 1'b0, 2, 1'b0);
    checkOutput("opfwd_ctrl", alu_ctrl, 64'h7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
